// File: rtl/gf180mcu_fd_sc_mcu7t5v0__req_fanout3_if.sv
// Upstream request bus plus the three 4-phase REQ/ACK destination channels.
// The slave modport is the fanout block; the master modport is the surrounding logic.
interface gf180mcu_fd_sc_mcu7t5v0__req_fanout3_if #(
  parameter int DW = 8
);
  logic          A_VALID;
  logic          A_READY;
  logic [1:0]    A_SEL;
  logic [DW-1:0] A_DATA;
  logic [DW-1:0] Z_DATA;
  logic          Z1_REQ;
  logic          Z2_REQ;
  logic          Z3_REQ;
  logic          Z1_ACK;
  logic          Z2_ACK;
  logic          Z3_ACK;

  modport slave (
    input  A_VALID, A_SEL, A_DATA, Z1_ACK, Z2_ACK, Z3_ACK,
    output A_READY, Z_DATA, Z1_REQ, Z2_REQ, Z3_REQ
  );

  modport master (
    output A_VALID, A_SEL, A_DATA, Z1_ACK, Z2_ACK, Z3_ACK,
    input  A_READY, Z_DATA, Z1_REQ, Z2_REQ, Z3_REQ
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__req_fanout3.sv
// Buffered request fanout: each upstream entry is dispatched to one of three
// 4-phase REQ/ACK channels, or broadcast to all of them.
module gf180mcu_fd_sc_mcu7t5v0__req_fanout3 #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__req_fanout3_if.slave bus,
  output logic BUSY
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sel_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    count_reg, count_next;
  logic          ready_reg;
  logic [2:0]    mask_reg, mask_next;
  logic [2:0]    done_reg, done_next;
  logic [2:0]    req_reg, req_next;
  logic [DW-1:0] z_data_reg, z_data_next;
  logic [2:0]    ack;
  logic          push, pop;
  logic          unused_supply;

  assign unused_supply = VDD & VSS;

  function automatic logic [2:0] sel_to_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    sel_to_mask = 3'b001;
      2'd1:    sel_to_mask = 3'b010;
      2'd2:    sel_to_mask = 3'b100;
      default: sel_to_mask = 3'b111;
    endcase
  endfunction

  function automatic logic ptr_inc(input logic ptr);
    ptr_inc = (ptr == 1'(DEPTH - 1)) ? 1'b0 : ptr + 1'b1;
  endfunction

  assign ack  = {bus.Z3_ACK, bus.Z2_ACK, bus.Z1_ACK};
  assign push = bus.A_VALID & ready_reg;

  // Buffer storage has no reset: occupancy alone says which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      sel_mem[wr_ptr_reg]  <= bus.A_SEL;
      data_mem[wr_ptr_reg] <= bus.A_DATA;
    end
  end

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ready_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
      ready_reg <= (count_next != 2'(DEPTH));
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    done_next   = done_reg;
    z_data_next = z_data_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) begin
          mask_next   = sel_to_mask(sel_mem[rd_ptr_reg]);
          z_data_next = data_mem[rd_ptr_reg];
          state_next  = REQ;
        end
      end
      REQ: begin
        // Sticky ack record: early responders in a broadcast wait for the rest.
        done_next = done_reg | (mask_reg & ack);
        if (done_next == mask_reg) state_next = RELEASE;
      end
      RELEASE: begin
        if ((ack & mask_reg) == 3'b000) begin
          pop        = 1'b1;
          done_next  = 3'b000;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    req_next = (state_next == REQ) ? mask_next : 3'b000;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      mask_reg   <= 3'b000;
      done_reg   <= 3'b000;
      req_reg    <= 3'b000;
      z_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      done_reg   <= done_next;
      req_reg    <= req_next;
      z_data_reg <= z_data_next;
    end
  end

  assign bus.A_READY = ready_reg;
  assign bus.Z_DATA  = z_data_reg;
  assign bus.Z1_REQ  = req_reg[0];
  assign bus.Z2_REQ  = req_reg[1];
  assign bus.Z3_REQ  = req_reg[2];
  assign BUSY        = (state_reg != IDLE) || (count_reg != 2'd0);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__req_fanout3.sv
// Scoreboard bench: every accepted entry queues its expected channel mask and
// payload; a monitor pops and compares on each rising REQ.
module tb_gf180mcu_fd_sc_mcu7t5v0__req_fanout3;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__req_fanout3_if #(.DW(8)) bus ();

  gf180mcu_fd_sc_mcu7t5v0__req_fanout3 #(.DW(8), .DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .bus(bus), .BUSY(busy)
  );

  always #5 clk = ~clk;

  logic [2:0] ack_man = 3'b000;
  logic [2:0] ack_auto = 3'b000;
  logic       auto_ack = 1'b0;
  logic [2:0] ack;
  int         resp_dly [3] = '{0, 0, 0};
  int         resp_cnt [3] = '{0, 0, 0};
  wire  [2:0] req_vec = {bus.Z3_REQ, bus.Z2_REQ, bus.Z1_REQ};

  assign ack        = auto_ack ? ack_auto : ack_man;
  assign bus.Z1_ACK = ack[0];
  assign bus.Z2_ACK = ack[1];
  assign bus.Z3_ACK = ack[2];

  // Well-behaved 4-phase responder: follows REQ after resp_dly extra cycles.
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (req_vec[n] != ack_auto[n]) begin
        if (resp_cnt[n] >= resp_dly[n]) begin
          ack_auto[n] = req_vec[n];
          resp_cnt[n] = 0;
        end else begin
          resp_cnt[n]++;
        end
      end else begin
        resp_cnt[n] = 0;
      end
    end
  end

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] sel_mask(input logic [1:0] sel);
    return (sel == 2'd3) ? 3'b111 : 3'(1 << sel);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push_entry(input logic [1:0] sel, input logic [7:0] data, output int waited);
    logic rdy;
    bit   done;
    bit   timed_out;
    bus.A_VALID = 1'b1;
    bus.A_SEL   = sel;
    bus.A_DATA  = data;
    waited = 0;
    done = 0;
    timed_out = 0;
    while (!done) begin
      rdy = bus.A_READY;
      @(negedge clk);
      if (rdy) done = 1;
      else begin
        waited++;
        if (waited > 300) begin
          check("push_timeout", 32'd0, 32'd1);
          timed_out = 1;
          done = 1;
        end
      end
    end
    if (!timed_out) exp_q.push_back('{mask: sel_mask(sel), data: data});
    $display("push sel=%0d data=0x%02h waited=%0d", sel, data, waited);
    bus.A_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    tick(cycles);
    rst = 1'b0;
  endtask

  initial begin
    int          w;
    logic [2:0]  req_prev = 3'b000;
    logic [7:0]  data_prev = 8'h00;
    bus.A_VALID = 1'b0;
    bus.A_SEL   = 2'd0;
    bus.A_DATA  = 8'h00;
    fork
      begin : main_seq
        // Reset and single unicast
        do_reset(2);
        check("rst_req", 32'(req_vec), 32'd0);
        check("rst_zdata", 32'(bus.Z_DATA), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.A_READY), 32'd1);
        push_entry(2'd1, 8'hA5, w);
        check("uni_req_early", 32'(req_vec), 32'd0);
        tick(1);
        check("uni_req_rise", 32'(req_vec), 32'b010);
        check("uni_zdata", 32'(bus.Z_DATA), 32'hA5);
        tick(1);
        check("uni_req_hold", 32'(req_vec), 32'b010);
        ack_man = 3'b010;
        tick(1);
        check("uni_req_fall", 32'(req_vec), 32'd0);
        check("uni_busy_release", 32'(busy), 32'd1);
        ack_man = 3'b000;
        tick(1);
        check("uni_busy_done", 32'(busy), 32'd0);

        // Broadcast with staggered acks
        push_entry(2'd3, 8'h3C, w);
        tick(1);
        for (int k = 0; k <= 6; k++) begin
          check("bc_req_all", 32'(req_vec), 32'b111);
          if (k == 1) ack_man[0] = 1'b1;
          if (k == 4) ack_man[2] = 1'b1;
          if (k == 6) ack_man[1] = 1'b1;
          tick(1);
        end
        check("bc_req_drop", 32'(req_vec), 32'd0);
        ack_man = 3'b010;
        tick(1);
        check("bc_wait_ack_low", 32'(busy), 32'd1);
        ack_man = 3'b000;
        tick(1);
        check("bc_popped", 32'(busy), 32'd0);

        // Full buffer: acks held low
        push_entry(2'd0, 8'h11, w);
        push_entry(2'd1, 8'h22, w);
        check("full_ready", 32'(bus.A_READY), 32'd0);
        check("full_req_first", 32'(req_vec), 32'b001);
        tick(2);
        check("full_ready_held", 32'(bus.A_READY), 32'd0);
        auto_ack = 1'b1;
        push_entry(2'd2, 8'h33, w);
        check("full_third_held", 32'(w > 0), 32'd1);
        wait_idle();

        // Pointer wrap with immediate acks
        resp_dly = '{0, 0, 0};
        for (int i = 0; i < 10; i++) push_entry(2'(i % 3), 8'(8'h40 + i), w);
        wait_idle();
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random responder delays
        for (int i = 0; i < 40; i++) begin
          for (int n = 0; n < 3; n++) resp_dly[n] = int'($urandom_range(0, 3));
          push_entry(2'($urandom_range(0, 3)), 8'($urandom), w);
          tick(int'($urandom_range(0, 3)));
        end
        wait_idle();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset while in REQ with two entries buffered
        auto_ack = 1'b0;
        ack_man  = 3'b000;
        tick(2);
        push_entry(2'd1, 8'h77, w);
        push_entry(2'd2, 8'h88, w);
        check("mid_in_req", 32'(req_vec), 32'b010);
        do_reset(1);
        check("mid_req", 32'(req_vec), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(bus.A_READY), 32'd1);
        auto_ack = 1'b1;
        push_entry(2'd0, 8'h99, w);
        wait_idle();
        check("mid_drained", 32'(exp_q.size()), 32'd0);

        // Foreign and stale ACK on Z3
        auto_ack = 1'b0;
        ack_man  = 3'b100;
        tick(2);
        push_entry(2'd0, 8'h5A, w);
        tick(1);
        check("foreign_req", 32'(req_vec), 32'b001);
        tick(2);
        check("foreign_ignored", 32'(req_vec), 32'b001);
        ack_man = 3'b101;
        tick(1);
        check("foreign_req_fall", 32'(req_vec), 32'd0);
        ack_man = 3'b100;
        tick(1);
        check("foreign_done", 32'(busy), 32'd0);
        push_entry(2'd2, 8'hC3, w);
        tick(1);
        check("stale_req", 32'(req_vec), 32'b100);
        tick(1);
        check("stale_release", 32'(req_vec), 32'd0);
        tick(2);
        check("stale_wait", 32'(busy), 32'd1);
        ack_man = 3'b000;
        tick(1);
        check("stale_popped", 32'(busy), 32'd0);
        tick(2);
      end
      begin : monitor
        logic [2:0] rq;
        exp_t       e;
        forever begin
          @(negedge clk);
          rq = req_vec;
          if (rst) begin
            req_prev = 3'b000;
          end else begin
            if (req_prev == 3'b000 && rq != 3'b000) begin
              if (exp_q.size() == 0) begin
                check("dispatch_unexpected", 32'(rq), 32'd0);
              end else begin
                e = exp_q.pop_front();
                $display("dispatch req=%03b data=0x%02h (expect %03b 0x%02h)", rq, bus.Z_DATA, e.mask, e.data);
                check("dispatch_mask", 32'(rq), 32'(e.mask));
                check("dispatch_data", 32'(bus.Z_DATA), 32'(e.data));
              end
            end else if (req_prev != 3'b000 && rq != 3'b000) begin
              check("req_stable", 32'(rq), 32'(req_prev));
              check("zdata_stable", 32'(bus.Z_DATA), 32'(data_prev));
            end
            req_prev  = rq;
            data_prev = bus.Z_DATA;
          end
        end
      end
      begin : watchdog
        repeat (40000) @(negedge clk);
        check("global_timeout", 32'd1, 32'd0);
      end
    join_any
    disable fork;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
